// File: rtl/min_reduce_collector_pkg.sv
// Shared widths, lane count and stage-B state encoding for the MIN2 collector.
package min_reduce_collector_pkg;

    localparam int IDX_W_DEF = 16;
    localparam int VAL_W_DEF = 14;
    localparam int CNT_W_DEF = 16;
    localparam int NUM_LANES = 4;

    typedef enum logic [0:0] {
        FIRST = 1'b0,
        ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/min_reduce_collector_lane_reduce.sv
// Combinational 4->1 minimum tree; ties resolve toward the lowest lane.
module min4_lane_reduce
    import min_reduce_collector_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int VAL_W = VAL_W_DEF
) (
    input  logic [NUM_LANES-1:0][IDX_W-1:0] idx_i,
    input  logic [NUM_LANES-1:0][VAL_W-1:0] val_i,
    output logic [IDX_W-1:0]                idx_o,
    output logic [VAL_W-1:0]                val_o
);

    logic [1:0][IDX_W-1:0] pair_idx;
    logic [1:0][VAL_W-1:0] pair_val;
    logic                  sel_hi;

    // Upper operand only wins on strict less-than, so equal values keep the lower lane.
    generate
        for (genvar p = 0; p < 2; p++) begin : g_pair
            logic take_odd;
            assign take_odd    = val_i[2*p+1] < val_i[2*p];
            assign pair_idx[p] = take_odd ? idx_i[2*p+1] : idx_i[2*p];
            assign pair_val[p] = take_odd ? val_i[2*p+1] : val_i[2*p];
        end
    endgenerate

    assign sel_hi = pair_val[1] < pair_val[0];
    assign idx_o  = sel_hi ? pair_idx[1] : pair_idx[0];
    assign val_o  = sel_hi ? pair_val[1] : pair_val[0];

endmodule

// File: rtl/min_reduce_collector.sv
// Frame-wide minimum collector: per-beat lane reduce, then running accumulate
// with a registered publish and one-cycle Best_Done on the frame's trigger beat.
module min_reduce_collector
    import min_reduce_collector_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int VAL_W = VAL_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MIN2_Valid,
    input  logic             MIN2_TriggerBoss,
    input  logic [IDX_W-1:0] MIN2_Minimum1Index,
    input  logic [IDX_W-1:0] MIN2_Minimum2Index,
    input  logic [IDX_W-1:0] MIN2_Minimum3Index,
    input  logic [IDX_W-1:0] MIN2_Minimum4Index,
    input  logic [VAL_W-1:0] MIN2_Minimum1Value,
    input  logic [VAL_W-1:0] MIN2_Minimum2Value,
    input  logic [VAL_W-1:0] MIN2_Minimum3Value,
    input  logic [VAL_W-1:0] MIN2_Minimum4Value,
    output logic [IDX_W-1:0] Best_Index,
    output logic [VAL_W-1:0] Best_Value,
    output logic [CNT_W-1:0] Best_Count,
    output logic             Best_Done,
    output logic             Busy
);

    logic [NUM_LANES-1:0][IDX_W-1:0] lane_idx;
    logic [NUM_LANES-1:0][VAL_W-1:0] lane_val;
    logic [IDX_W-1:0]                red_idx;
    logic [VAL_W-1:0]                red_val;

    // Lane 1 sits at element 0 so the tree's tie rule favours the lowest lane number.
    assign lane_idx = {MIN2_Minimum4Index, MIN2_Minimum3Index,
                       MIN2_Minimum2Index, MIN2_Minimum1Index};
    assign lane_val = {MIN2_Minimum4Value, MIN2_Minimum3Value,
                       MIN2_Minimum2Value, MIN2_Minimum1Value};

    min4_lane_reduce #(
        .IDX_W (IDX_W),
        .VAL_W (VAL_W)
    ) u_reduce (
        .idx_i (lane_idx),
        .val_i (lane_val),
        .idx_o (red_idx),
        .val_o (red_val)
    );

    logic             a_vld_q, a_last_q;
    logic [IDX_W-1:0] a_idx_q;
    logic [VAL_W-1:0] a_val_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_q  <= 1'b0;
            a_last_q <= 1'b0;
            a_idx_q  <= '0;
            a_val_q  <= '1;
        end else begin
            a_vld_q  <= MIN2_Valid;
            a_last_q <= MIN2_Valid & MIN2_TriggerBoss;
            if (MIN2_Valid) begin
                a_idx_q <= red_idx;
                a_val_q <= red_val;
            end
        end
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] run_idx_q, run_idx_d;
    logic [VAL_W-1:0] run_val_q, run_val_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [VAL_W-1:0] best_val_q, best_val_d;
    logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
    logic             done_d;
    logic             done_q;
    logic             a_wins;
    logic [CNT_W-1:0] cnt_inc;

    assign a_wins  = a_val_q < run_val_q;
    assign cnt_inc = (&run_cnt_q) ? run_cnt_q : run_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        run_idx_d  = run_idx_q;
        run_val_d  = run_val_q;
        run_cnt_d  = run_cnt_q;
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        best_cnt_d = best_cnt_q;
        done_d     = 1'b0;
        if (a_vld_q) begin
            case (state_q)
                FIRST: begin
                    run_idx_d = a_idx_q;
                    run_val_d = a_val_q;
                    run_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d   = a_last_q ? FIRST : ACCUM;
                end
                default: begin
                    if (a_wins) begin
                        run_idx_d = a_idx_q;
                        run_val_d = a_val_q;
                    end
                    run_cnt_d = cnt_inc;
                    if (a_last_q) state_d = FIRST;
                end
            endcase
            // Publish from the next-run values so the trigger beat itself takes part.
            if (a_last_q) begin
                best_idx_d = run_idx_d;
                best_val_d = run_val_d;
                best_cnt_d = run_cnt_d;
                done_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FIRST;
            run_idx_q  <= '0;
            run_val_q  <= '1;
            run_cnt_q  <= '0;
            best_idx_q <= '0;
            best_val_q <= '1;
            best_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_idx_q  <= run_idx_d;
            run_val_q  <= run_val_d;
            run_cnt_q  <= run_cnt_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
            best_cnt_q <= best_cnt_d;
            done_q     <= done_d;
        end
    end

    assign Best_Index = best_idx_q;
    assign Best_Value = best_val_q;
    assign Best_Count = best_cnt_q;
    assign Best_Done  = done_q;
    assign Busy       = (state_q == ACCUM);

endmodule

// File: doc/min_reduce_collector.md
Name: min_reduce_collector

Overview:
- Consumer at the far end of the MIN1→MIN2 pipeline register.
- Each valid beat carries four (index, value) minimum candidates. The block reduces them to one per beat, then tracks a running frame-wide minimum.
- The beat flagged by TriggerBoss closes the frame. The block then publishes the winning index/value with a one-cycle done pulse to the downstream boss/control logic.
- Two-stage pipeline: lane reduce, then running accumulate.

Parameters:
- IDX_W, 16, candidate index width
- VAL_W, 14, candidate value width (unsigned)
- CNT_W, 16, beat-counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- MIN2_Valid  in  1  qualifies all MIN2_* inputs this cycle
- MIN2_TriggerBoss  in  1  last beat of frame; ignored when MIN2_Valid=0
- MIN2_Minimum1Index … MIN2_Minimum4Index  in  IDX_W each  lane 1..4 candidate index
- MIN2_Minimum1Value … MIN2_Minimum4Value  in  VAL_W each  lane 1..4 candidate value
- Best_Index  out  IDX_W  frame winner index, held until next publish
- Best_Value  out  VAL_W  frame winner value, held until next publish
- Best_Count  out  CNT_W  valid beats in published frame
- Best_Done  out  1  one-cycle pulse when Best_* are updated
- Busy  out  1  high while a frame is open (at least one beat accepted, trigger not yet accepted)

Behaviour:
- Reset (rst=1 at clk edge): Best_Index=0, Best_Value=all-ones, Best_Count=0, Best_Done=0, Busy=0. All pipeline valids cleared and FSM→FIRST. Reset mid-frame discards the partial frame; no Done is produced for it.
- Input is accepted every cycle MIN2_Valid=1. There is no backpressure.
- Stage A (registered, 1 cycle):
  - Unsigned min of the 4 values. Tie → lowest lane number wins.
  - Registers A_Valid, A_Last (= TriggerBoss), A_Index, A_Value.
- Stage B, FSM with states FIRST and ACCUM:
  - FIRST, A_Valid=1: load run_idx/run_val from stage A; run_cnt=1.
    - If A_Last: publish immediately and stay in FIRST.
    - Else: go to ACCUM.
  - ACCUM, A_Valid=1:
    - If A_Value < run_val (strict), replace run_idx/run_val. Ties keep the earlier beat.
    - run_cnt saturates at all-ones.
    - If A_Last: publish, using the comparison result of this same beat, and go to FIRST.
  - A_Valid=0: hold state.
- Publish: Best_Index/Best_Value/Best_Count are registered and Best_Done=1 for exactly one cycle.
- Latency: trigger beat presented in cycle t → Best_Done high in cycle t+2.
- Back-to-back frames: the first beat of the next frame may arrive in cycle t+1. The FSM has already returned to FIRST, so no bubble is needed.
- Busy=1 in ACCUM, plus the cycle after a non-last beat is captured while in FIRST (equivalently, Busy = state==ACCUM).
- Trigger with MIN2_Valid=0 has no effect.
- Single-beat frame (trigger on first beat): the winner is that beat's lane minimum and Best_Count=1.

Decomposition:
- Shared package: IDX_W/VAL_W/CNT_W defaults, FSM state enum {FIRST, ACCUM}, lane count constant 4.
- One natural sub-module: min4_lane_reduce. It is a combinational 4→1 tree with tie-to-lowest-lane, instantiated ahead of the stage-A register.

Test Plan:
- Reset: rst held 2 cycles → Best_Value=0x3FFF, Best_Index=0, Best_Count=0, Best_Done=0, Busy=0.
- Single beat with trigger, values {50,20,20,90}, indices {1,2,3,4} → 2 cycles later Done=1, Best_Index=2 (tie→lane 2), Best_Value=20, Best_Count=1.
- Frame of 3 beats with lane minima 30@idx7, 12@idx9, 12@idx11, trigger on beat 3 → Best_Index=9, Best_Value=12 (tie keeps earlier), Best_Count=3.
- Back-to-back frames: frame A ends cycle t with min 5@idx3. Frame B is a single triggered beat at t+1 with min 40@idx8 → Done at t+2 (A: 3/5) and t+3 (B: 8/40). Frame B is not polluted by A.
- Gaps and stray trigger: valid beats separated by idle cycles, with TriggerBoss=1 while Valid=0 → no early Done; the result equals the gap-free run.
- Reset mid-frame after 2 beats, then a new single triggered beat 7@idx1 → only one Done, reporting 1/7/count 1.
